wb_mem_responder: RTL



---
 rtl/wb_mem_responder_pkg.sv | 14 +
 rtl/wb_resp_mem.sv | 36 +++
 rtl/wb_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wb_mem_responder_pkg.sv
// Shared types and constants for the Wishbone memory responder.
// The FSM state type is exported so that checkers can bind to it.
package wb_mem_responder_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} resp_state_t;

  localparam int WB_SEL_W = 4;
  localparam int WB_DAT_W = 32;

  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/wb_resp_mem.sv
// Byte-enable register array behind the responder.
// Reads are combinational; writes and the reset clear happen on the clock edge.
module wb_resp_mem
  import wb_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we,
  input  logic [WB_SEL_W-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [WB_DAT_W-1:0] wdata,
  output logic [WB_DAT_W-1:0] rdata
);

  logic [WB_DAT_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic (B4) slave backed by a small word memory, with
// configurable wait states and error termination for unmapped addresses.
module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [31:0]         adr_i,
  input  logic [WB_DAT_W-1:0] dat_i,
  input  logic [WB_SEL_W-1:0] sel_i,
  input  logic                we_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  output logic                ack_o,
  output logic                err_o,
  output logic [WB_DAT_W-1:0] dat_o,
  output logic                busy_o,
  output logic [15:0]         wr_count_o,
  output resp_state_t         state_o
);

  localparam int          IDX_W     = idx_width(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  // Handshake: a request is offered while cyc_i & stb_i are high and is taken
  // in IDLE; it completes with exactly one ack_o or err_o pulse, after which
  // DONE ignores stb_i for one cycle so a late-dropping master is not re-served.
  resp_state_t         state_q, state_d;
  logic [31:0]         adr_q;
  logic [WB_DAT_W-1:0] dat_q;
  logic [WB_SEL_W-1:0] sel_q;
  logic                we_q;
  logic [2:0]          wait_q;
  logic [WB_DAT_W-1:0] rd_q;
  logic [15:0]         wr_cnt_q;

  logic                req, enter_resp, commit;
  logic [31:0]         cur_adr, offset;
  logic [WB_DAT_W-1:0] cur_dat, mem_rdata;
  logic [WB_SEL_W-1:0] cur_sel;
  logic                cur_we, cur_hit;

  assign req = cyc_i & stb_i;

  // In IDLE the request is still on the bus; afterwards only the latched copy counts.
  assign cur_adr = (state_q == IDLE) ? adr_i : adr_q;
  assign cur_dat = (state_q == IDLE) ? dat_i : dat_q;
  assign cur_sel = (state_q == IDLE) ? sel_i : sel_q;
  assign cur_we  = (state_q == IDLE) ? we_i  : we_q;

  assign offset  = cur_adr - ADDR_BASE;
  assign cur_hit = (cur_adr[1:0] == 2'b00) && (cur_adr >= ADDR_BASE) && (offset < SPAN);
  assign commit  = enter_resp & cur_hit & cur_we;

  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    ack_o      = 1'b0;
    err_o      = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy_o = 1'b1;
        if (!req) begin
          state_d = IDLE;
        end else if (wait_q == 3'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        busy_o  = 1'b1;
        ack_o   = cur_hit;
        err_o   = ~cur_hit;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      wait_q   <= '0;
      rd_q     <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        adr_q  <= adr_i;
        dat_q  <= dat_i;
        sel_q  <= sel_i;
        we_q   <= we_i;
        wait_q <= WAIT_LOAD;
      end else if (state_q == WAIT && wait_q != 3'd0) begin
        wait_q <= wait_q - 3'd1;
      end
      // Only non-zero during RESP, so dat_o never shows stale data.
      rd_q <= (enter_resp && cur_hit && !cur_we) ? mem_rdata : '0;
      if (commit) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  wb_resp_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .we   (commit),
    .be   (cur_sel),
    .idx  (offset[IDX_W+1:2]),
    .wdata(cur_dat),
    .rdata(mem_rdata)
  );

  assign dat_o      = rd_q;
  assign wr_count_o = wr_cnt_q;
  assign state_o    = state_q;

endmodule
